// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word type, RAM handshake state,
// arbiter state encoding and the arbiter's RAM request payload.
package cpu_types_pkg;

   localparam int unsigned WORD_W           = 32;
   localparam int unsigned BLOCK_WORDS_DEF  = 2;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_DGRANT = 2'd1,
      ARB_IGRANT = 2'd2
   } arb_state_t;

   // Request presented to the RAM port by whichever cache owns it.
   typedef struct packed {
      logic  ren;
      logic  wen;
      word_t addr;
      word_t store;
   } ram_req_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM signal bundle seen by the memory arbiter.
//   slave  : arbiter side (takes cache requests and RAM status, drives RAM)
//   master : environment side (caches + RAM model)
interface cache_mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter. Ports: CLK, nRST (async active-low),
// inc (count up, holds at LIMIT), clr (priority clear), sat (registered,
// high while the count equals LIMIT).
module arb_starve_ctr
   import cpu_types_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
   input  logic CLK,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   // Next count: clear wins over increment, increment holds at LIMIT.
   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (inc && (cnt != W'(LIMIT)))
         cnt_nxt = cnt + W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
         sat <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         sat <= (cnt_nxt == W'(LIMIT));
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache. dcache has priority and
// keeps the port for a whole BLOCK_WORDS burst; after STARVE_LIMIT
// consecutive dcache bursts with iREN pending the icache is forced a grant.
// Arbitration is combinational from ARB_IDLE, so the RAM sees a request in
// the same cycle it is raised.
// Ports: CLK, nRST (async active-low), cif (cache_mem_arbiter_if.slave).
// Optional macro ARB_PERF_EN adds dgrant_cnt (completed dcache words) and
// ifetch_stall_cnt (cycles with iREN && iwait).
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS  = BLOCK_WORDS_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                CLK,
   input  logic                nRST,
   cache_mem_arbiter_if.slave  cif
`ifdef ARB_PERF_EN
   ,
   output word_t               dgrant_cnt,
   output word_t               ifetch_stall_cnt
`endif
);

   localparam int unsigned WCNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;
   logic              dreq;
   logic              acc;
   logic              dsel;
   logic              isel;
   logic              starve_sat;
   logic              starve_inc;
   logic              starve_clr;
   logic              iwait_c;
   ram_req_t          req;

   assign dreq = cif.dREN | cif.dWEN;
   assign acc  = (cif.ramstate == ACCESS);

   // Who owns the port this cycle; gated by nRST so enables drop with reset.
   always_comb begin
      dsel = 1'b0;
      isel = 1'b0;
      if (nRST) begin
         case (state)
            ARB_IDLE: begin
               if (dreq && !(cif.iREN && starve_sat))
                  dsel = 1'b1;
               else if (cif.iREN)
                  isel = 1'b1;
            end
            ARB_DGRANT: dsel = 1'b1;
            ARB_IGRANT: isel = 1'b1;
            default: ;
         endcase
      end
   end

   // RAM request and cache handshakes for the current owner.
   always_comb begin
      req = '{ren: 1'b0, wen: 1'b0, addr: cif.daddr, store: cif.dstore};
      if (dsel) begin
         req.ren = cif.dREN;
         req.wen = cif.dWEN;
      end else if (isel) begin
         req.ren  = 1'b1;
         req.addr = cif.iaddr;
      end
   end

   assign iwait_c      = !(isel && acc);
   assign cif.iwait    = iwait_c;
   assign cif.dwait    = !(dsel && dreq && acc);
   assign cif.iload    = cif.ramload;
   assign cif.dload    = cif.ramload;
   assign cif.ramREN   = req.ren;
   assign cif.ramWEN   = req.wen;
   assign cif.ramaddr  = req.addr;
   assign cif.ramstore = req.store;

   // Next state, burst word count and starvation bookkeeping.
   always_comb begin
      state_nxt  = ARB_IDLE;
      wcnt_nxt   = wcnt;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      if (dsel) begin
         if (!dreq) begin
            // dcache withdrew mid-burst: abandon it without touching starve.
            wcnt_nxt = '0;
         end else if (acc) begin
            if (wcnt == WCNT_W'(BLOCK_WORDS - 1)) begin
               wcnt_nxt   = '0;
               starve_inc = cif.iREN;
               starve_clr = !cif.iREN;
            end else begin
               wcnt_nxt  = wcnt + WCNT_W'(1);
               state_nxt = ARB_DGRANT;
            end
         end else begin
            state_nxt = ARB_DGRANT;
         end
      end else if (isel) begin
         if (acc)
            starve_clr = 1'b1;
         else if (cif.iREN)
            state_nxt = ARB_IGRANT;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= ARB_IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (starve_inc),
      .clr  (starve_clr),
      .sat  (starve_sat)
   );

`ifdef ARB_PERF_EN
   // Free-running performance counters, wrap at 2^32.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dgrant_cnt       <= '0;
         ifetch_stall_cnt <= '0;
      end else begin
         if (dsel && dreq && acc)
            dgrant_cnt <= dgrant_cnt + 32'd1;
         if (cif.iREN && iwait_c)
            ifetch_stall_cnt <= ifetch_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: the bench plays both caches and the
// RAM, a per-cycle ownership model checks every output on the falling edge,
// and the stimulus thread adds hand-computed literal checks.
module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int BW = 2;
   localparam int SL = 4;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   cache_mem_arbiter_if cif ();

`ifdef ARB_PERF_EN
   word_t dgc, isc;
`endif

   cache_mem_arbiter #(.BLOCK_WORDS(BW), .STARVE_LIMIT(SL)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .cif  (cif)
`ifdef ARB_PERF_EN
      ,
      .dgrant_cnt       (dgc),
      .ifetch_stall_cnt (isc)
`endif
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: owner 0=none 1=dcache 2=icache ----------------
   int          m_owner  = 0;
   int          m_words  = 0;
   int          m_starve = 0;
   logic [31:0] m_dcnt   = 0;
   logic [31:0] m_scnt   = 0;

   always @(negedge CLK) begin : cmp
      int   g;
      logic dreq, acc, e_iwait, e_dwait;
      if (!nRST) begin
         chk("rst ramREN", {31'b0, cif.ramREN}, 32'd0);
         chk("rst ramWEN", {31'b0, cif.ramWEN}, 32'd0);
         chk("rst iwait",  {31'b0, cif.iwait},  32'd1);
         chk("rst dwait",  {31'b0, cif.dwait},  32'd1);
         m_owner = 0; m_words = 0; m_starve = 0; m_dcnt = 0; m_scnt = 0;
`ifdef ARB_PERF_EN
         chk("rst dgrant_cnt", dgc, 32'd0);
         chk("rst ifetch_stall_cnt", isc, 32'd0);
`endif
      end else begin
         dreq = cif.dREN | cif.dWEN;
         acc  = (cif.ramstate == ACCESS);
         g    = m_owner;
         if (g == 0) begin
            if (dreq && !(cif.iREN && m_starve == SL)) g = 1;
            else if (cif.iREN)                          g = 2;
         end
         e_iwait = !(g == 2 && acc);
         e_dwait = !(g == 1 && dreq && acc);
         chk("iwait", {31'b0, cif.iwait}, {31'b0, e_iwait});
         chk("dwait", {31'b0, cif.dwait}, {31'b0, e_dwait});
         chk("iload", cif.iload, cif.ramload);
         chk("dload", cif.dload, cif.ramload);
         if (g == 1) begin
            chk("ramREN(d)",  {31'b0, cif.ramREN}, {31'b0, cif.dREN});
            chk("ramWEN(d)",  {31'b0, cif.ramWEN}, {31'b0, cif.dWEN});
            chk("ramaddr(d)", cif.ramaddr, cif.daddr);
            chk("ramstore(d)", cif.ramstore, cif.dstore);
         end else if (g == 2) begin
            chk("ramREN(i)",  {31'b0, cif.ramREN}, 32'd1);
            chk("ramWEN(i)",  {31'b0, cif.ramWEN}, 32'd0);
            chk("ramaddr(i)", cif.ramaddr, cif.iaddr);
         end else begin
            chk("ramREN(idle)", {31'b0, cif.ramREN}, 32'd0);
            chk("ramWEN(idle)", {31'b0, cif.ramWEN}, 32'd0);
         end
`ifdef ARB_PERF_EN
         chk("dgrant_cnt", dgc, m_dcnt);
         chk("ifetch_stall_cnt", isc, m_scnt);
`endif
         // advance to the state after the coming rising edge
         if (cif.iREN && e_iwait) m_scnt = m_scnt + 1;
         if (g == 1) begin
            if (!dreq) begin
               m_owner = 0; m_words = 0;
            end else if (acc) begin
               m_dcnt  = m_dcnt + 1;
               m_words = m_words + 1;
               m_owner = 1;
               if (m_words == BW) begin
                  m_owner  = 0;
                  m_words  = 0;
                  m_starve = cif.iREN ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
               end
            end else begin
               m_owner = 1;
            end
         end else if (g == 2) begin
            if (acc) begin m_owner = 0; m_starve = 0; end
            else     m_owner = cif.iREN ? 2 : 0;
         end else begin
            m_owner = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic peek();
      #2;
   endtask

   int ilow;

   initial begin
      nRST = 1'b0;
      cif.iREN = 0; cif.iaddr = 32'h100;
      cif.dREN = 0; cif.dWEN = 0; cif.daddr = 0; cif.dstore = 0;
      cif.ramload = 32'hDEADBEEF; cif.ramstate = FREE;
      step(); step();
      peek();
      chk("T0 ramREN",  {31'b0, cif.ramREN}, 32'd0);
      chk("T0 iwait",   {31'b0, cif.iwait},  32'd1);
      chk("T0 dload",   cif.dload, 32'hDEADBEEF);
      step();
      nRST = 1'b1;

      // T1: icache fetch, 2 BUSY then ACCESS
      cif.iREN = 1; cif.iaddr = 32'h100; cif.ramstate = BUSY;
      peek();
      chk("T1 ramaddr", cif.ramaddr, 32'h100);
      ilow = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) cif.ramstate = ACCESS;
         if (c == 3) begin cif.iREN = 0; cif.ramstate = FREE; end
         peek();
         if (!cif.iwait) begin
            ilow++;
            chk("T1 iload", cif.iload, 32'hDEADBEEF);
         end
         step();
      end
      chk("T1 iwait low cycles", ilow, 32'd1);

      // T2: simultaneous dcache + icache, dcache burst first
      cif.iREN = 1; cif.dREN = 1; cif.daddr = 32'h200; cif.ramstate = ACCESS;
      peek();
      chk("T2 ramaddr w0", cif.ramaddr, 32'h200);
      chk("T2 iwait w0", {31'b0, cif.iwait}, 32'd1);
      step();
      cif.daddr = 32'h204;
      peek();
      chk("T2 ramaddr w1", cif.ramaddr, 32'h204);
      chk("T2 dwait w1", {31'b0, cif.dwait}, 32'd0);
      step();
      cif.dREN = 0;
      peek();
      chk("T2 ramaddr ifetch", cif.ramaddr, 32'h100);
      chk("T2 iwait ifetch", {31'b0, cif.iwait}, 32'd0);
      step();
      cif.iREN = 0; cif.ramstate = FREE;
      step();

      // T3: icache arrives mid-burst
      cif.dREN = 1; cif.daddr = 32'h200; cif.ramstate = ACCESS;
      step();
      cif.iREN = 1; cif.daddr = 32'h204; cif.ramstate = BUSY;
      peek();
      chk("T3 held ramaddr", cif.ramaddr, 32'h204);
      step();
      cif.ramstate = ACCESS;
      peek();
      chk("T3 w1 ramaddr", cif.ramaddr, 32'h204);
      chk("T3 w1 dwait", {31'b0, cif.dwait}, 32'd0);
      step();
      cif.dREN = 0;
      peek();
      chk("T3 ifetch ramaddr", cif.ramaddr, 32'h100);
      step();
      cif.iREN = 0; cif.ramstate = FREE;
      step();

      // T4: starvation, 4 bursts then a forced icache grant
      cif.iREN = 1; cif.iaddr = 32'h180; cif.dREN = 1; cif.ramstate = ACCESS;
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 2; w++) begin
            cif.daddr = 32'h400 + 32'(8 * b + 4 * w);
            peek();
            chk("T4 burst ramaddr", cif.ramaddr, cif.daddr);
            step();
         end
      end
      peek();
      chk("T4 forced ramaddr", cif.ramaddr, 32'h180);
      chk("T4 forced iwait", {31'b0, cif.iwait}, 32'd0);
      chk("T4 forced dwait", {31'b0, cif.dwait}, 32'd1);
      step();
      cif.daddr = 32'h420;
      peek();
      chk("T4 5th burst ramaddr", cif.ramaddr, 32'h420);
      step();
      cif.daddr = 32'h424;
      step();
      cif.dREN = 0; cif.iREN = 0; cif.ramstate = FREE;
      step();

      // T5: write burst with ERROR cycles
      cif.dWEN = 1; cif.daddr = 32'h300; cif.dstore = 32'h11; cif.ramstate = ERROR;
      for (int c = 0; c < 3; c++) begin
         peek();
         chk("T5 err dwait", {31'b0, cif.dwait}, 32'd1);
         chk("T5 err ramWEN", {31'b0, cif.ramWEN}, 32'd1);
         step();
      end
      cif.ramstate = ACCESS;
      peek();
      chk("T5 w0 ramstore", cif.ramstore, 32'h11);
      step();
      cif.daddr = 32'h304; cif.dstore = 32'h22;
      peek();
      chk("T5 w1 ramaddr", cif.ramaddr, 32'h304);
      chk("T5 w1 dwait", {31'b0, cif.dwait}, 32'd0);
      step();
      cif.dWEN = 0; cif.ramstate = FREE;
      peek();
      chk("T5 done ramWEN", {31'b0, cif.ramWEN}, 32'd0);
      step();

      // T6: reset during second burst word
      cif.dREN = 1; cif.daddr = 32'h500; cif.ramstate = ACCESS;
      step();
      cif.daddr = 32'h504; cif.ramstate = BUSY;
      peek();
      chk("T6 pre ramREN", {31'b0, cif.ramREN}, 32'd1);
      nRST = 1'b0;
      #1;
      chk("T6 async ramREN", {31'b0, cif.ramREN}, 32'd0);
      chk("T6 async dwait",  {31'b0, cif.dwait},  32'd1);
`ifdef ARB_PERF_EN
      chk("T6 dgrant_cnt", dgc, 32'd0);
`endif
      step();
      nRST = 1'b1; cif.daddr = 32'h500; cif.ramstate = ACCESS;
      peek();
      chk("T6 restart ramaddr", cif.ramaddr, 32'h500);
      step();
      cif.daddr = 32'h504;
      peek();
      chk("T6 restart w1 dwait", {31'b0, cif.dwait}, 32'd0);
      step();
      cif.dREN = 0; cif.ramstate = FREE;
      peek();
      chk("T6 idle ramREN", {31'b0, cif.ramREN}, 32'd0);
      step();

      // T7: dcache withdraws mid-burst, next burst restarts at word 0
      cif.dREN = 1; cif.daddr = 32'h600; cif.ramstate = ACCESS;
      step();
      cif.dREN = 0; cif.ramstate = BUSY;
      step();
      cif.dREN = 1; cif.daddr = 32'h700; cif.ramstate = ACCESS;
      step();
      cif.daddr = 32'h704;
      peek();
      chk("T7 w1 ramaddr", cif.ramaddr, 32'h704);
      step();
      cif.dREN = 0; cif.ramstate = FREE;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between icache and dcache.
- dcache requests have priority, and a dcache grant is locked for a whole block burst (BLOCK_WORDS words), so a 2-word load or writeback is never split by an instruction fetch.
- A starvation counter guarantees icache forward progress.
- Sits between the caches' caches_if signals and the RAM model.

Parameters:
BLOCK_WORDS, 2, words per dcache burst (dcache frame size); lock released after this many completed accesses.
STARVE_LIMIT, 4, consecutive completed dcache bursts while iREN is held, after which icache is forced a grant.

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  icache stall; 0 for one cycle when iload is valid
iload  out  32  instruction word
dREN  in  1  dcache read request
dWEN  in  1  dcache write request (mutually exclusive with dREN)
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  dcache stall; 0 for one cycle on completion
dload  out  32  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset values: state=ARB_IDLE, wcnt=0, starve=0. Outputs: iwait=1, dwait=1, ram* enables=0, iload/dload pass ramload.
- States (arb_state_t):
  - ARB_IDLE: no grant. RAM enables 0.
  - ARB_DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. dwait = (ramstate!=ACCESS). iwait=1.
  - ARB_IGRANT: ramREN=1, ramaddr=iaddr, ramWEN=0. iwait = (ramstate!=ACCESS). dwait=1.
- Grant selection, combinational in ARB_IDLE (zero-cycle arbitration; the RAM sees the request the same cycle):
  - If (dREN|dWEN) and !(iREN && starve==STARVE_LIMIT): act as ARB_DGRANT this cycle and register state=ARB_DGRANT.
  - Else if iREN: act as ARB_IGRANT.
  - Else stay idle.
- ARB_DGRANT:
  - Each cycle with ramstate==ACCESS: wcnt++.
  - When wcnt reaches BLOCK_WORDS-1 and ACCESS: wcnt=0, return to ARB_IDLE, and update starve: starve++ (saturating) if iREN, else starve=0.
  - If dREN and dWEN both drop before burst end (e.g. dcache hit after a partial sequence): wcnt=0, ARB_IDLE, no starve update.
- ARB_IGRANT:
  - On ACCESS: ARB_IDLE, starve=0.
  - If iREN drops: ARB_IDLE.
- ramstate==ERROR: treated as BUSY (keep waiting; no counter updates).
- Simultaneous iREN and dREN/dWEN in ARB_IDLE: dcache wins unless starve==STARVE_LIMIT.
- Address change mid-burst: passed through; the dcache owns sequencing (daddr, daddr+4). The arbiter only counts words.
- Reset asserted mid-burst: immediate return to reset values. RAM enables drop asynchronously.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined:
  - Adds outputs dgrant_cnt[31:0] and ifetch_stall_cnt[31:0].
  - dgrant_cnt increments on each completed dcache word.
  - ifetch_stall_cnt increments on every cycle with iREN && iwait.
  - Both clear on nRST and wrap at 2^32.
- When undefined: no ports, no counters, and behaviour otherwise identical.

Decomposition:
- cpu_types_pkg already holds word_t and ramstate_t.
- Add arb_state_t (ARB_IDLE, ARB_DGRANT, ARB_IGRANT) to cpu_types_pkg.
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clr/sat output, width $clog2(STARVE_LIMIT+1).

Test Plan:
1. Reset, then iREN=1, iaddr=0x100, RAM gives ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> iwait low exactly 1 cycle with iload=0xDEADBEEF; state returns to ARB_IDLE.
2. dREN=1 at 0x200 and iREN=1 in the same cycle -> dcache granted; ramaddr=0x200 then 0x204 (two ACCESS); iwait stays 1 until both complete; then icache granted.
3. Icache arrives mid-burst (after first dcache ACCESS) -> grant held; second dcache word completes before ramaddr switches to iaddr.
4. Starvation: iREN held while dcache issues 5 back-to-back bursts, STARVE_LIMIT=4 -> after the 4th burst the icache is granted before the 5th; starve clears to 0.
5. dWEN burst to 0x300/0x304, dstore=0x11/0x22, with ramstate=ERROR for 3 cycles -> dwait held, no wcnt advance; completes correctly after ACCESS.
6. nRST asserted during the second word of a dcache burst -> ramREN/ramWEN=0 immediately; state=ARB_IDLE, wcnt=0. With ARB_PERF_EN, counters read 0.
